// File: rtl/mac4_pkg.sv
// mac4_pkg -- shared definitions for the mac4_accum block.
//   state_t : FSM encoding (IDLE=2'b00, ACC=2'b01, HOLD=2'b10)
//   PROD_W  : width of the upstream 4x4 product
// Literals carry an ST_ prefix so they cannot collide with the ACC port
// of mac4_accum when the package is wildcard-imported.
package mac4_pkg;

    localparam int PROD_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

endpackage

// File: rtl/mac4_add.sv
// mac4_add -- ACC_W-bit add of a zero-extended product, with carry out.
//   acc   : current accumulator value
//   p     : unsigned product (PROD_W bits), zero-extended
//   sum   : new accumulator value
//   carry : carry out of bit ACC_W-1
// Build option: MAC4_ACCUM_SAT_EN -- when defined, an add that carries out
// returns all-ones instead of the wrapped sum. Once saturated, any further
// add either carries again or adds zero, so the value stays all-ones.
module mac4_add
    import mac4_pkg::*;
#(
    parameter int ACC_W = 12
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] p,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] full;

    assign full  = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, p};
    assign carry = full[ACC_W];

`ifdef MAC4_ACCUM_SAT_EN
    assign sum = carry ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
    assign sum = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/mac4_accum.sv
// mac4_accum -- burst accumulator for products from a 4x4 multiplier.
//   clk, rst_n : clock, asynchronous active-low reset
//   start, len : begin a burst of len products (sampled in IDLE only)
//   P, in_valid, in_ready    : product input handshake (ready only in ACC)
//   ACC, OVF, out_valid, out_ready : result handshake (valid only in HOLD)
//   busy       : FSM is not in IDLE
// Build option: MAC4_ACCUM_SAT_EN (saturating accumulation, see mac4_add).
// len=0 skips ACC entirely and presents a zero result.
module mac4_accum
    import mac4_pkg::*;
#(
    parameter int ACC_W = 12,
    parameter int LEN_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [PROD_W-1:0] P,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACC_W-1:0]  ACC,
    output logic              OVF,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  cnt;
    logic [ACC_W-1:0]  acc_q, sum;
    logic              ovf_q, carry, accept, load;

    assign in_ready  = (state == ST_ACC);
    assign out_valid = (state == ST_HOLD);
    assign busy      = (state != ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign load      = (state == ST_IDLE) && start;
    assign ACC       = acc_q;
    assign OVF       = ovf_q;

    mac4_add #(.ACC_W(ACC_W)) u_add (
        .acc   (acc_q),
        .p     (P),
        .sum   (sum),
        .carry (carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = (len == '0) ? ST_HOLD : ST_ACC;
            ST_ACC:  if (accept && cnt == LEN_W'(1)) state_nxt = ST_HOLD;
            ST_HOLD: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Result registers are cleared only when a new burst loads, so ACC/OVF
    // stay visible through HOLD and back into IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            cnt   <= len;
        end else if (accept) begin
            acc_q <= sum;
            ovf_q <= ovf_q | carry;
            cnt   <= cnt - LEN_W'(1);
        end
    end

endmodule

// File: tb/tb_mac4_accum.sv
// tb_mac4_accum -- directed self-checking bench for mac4_accum.
// Two instances share all inputs: ACC_W=12 (default) and ACC_W=8 for the
// overflow vectors. Inputs change and outputs are sampled on the falling edge.
module tb_mac4_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  len = '0;
    logic [7:0]  P = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready12, ovf12, out_valid12, busy12;
    logic [11:0] acc12;
    logic        in_ready8, ovf8, out_valid8, busy8;
    logic [7:0]  acc8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac4_accum #(.ACC_W(12), .LEN_W(4)) dut12 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .P(P),
        .in_valid(in_valid), .in_ready(in_ready12), .ACC(acc12), .OVF(ovf12),
        .out_valid(out_valid12), .out_ready(out_ready), .busy(busy12)
    );

    mac4_accum #(.ACC_W(8), .LEN_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .P(P),
        .in_valid(in_valid), .in_ready(in_ready8), .ACC(acc8), .OVF(ovf8),
        .out_valid(out_valid8), .out_ready(out_ready), .busy(busy8)
    );

    // Hand the result back and confirm the return to IDLE.
    task automatic drain(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (busy12 !== 1'b0 || out_valid12 !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain: busy=%b out_valid=%b, want 0 0", name, busy12, out_valid12);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (acc12 !== 12'h000 || ovf12 !== 1'b0 || in_ready12 !== 1'b0 ||
            out_valid12 !== 1'b0 || busy12 !== 1'b0) begin
            errors++;
            $display("FAIL reset: acc=%h ovf=%b rdy=%b ov=%b busy=%b, want 000 0 0 0 0",
                     acc12, ovf12, in_ready12, out_valid12, busy12);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        @(negedge clk);
        start = 1'b1; len = 4'd2;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (in_ready12 !== 1'b1 || busy12 !== 1'b1) begin
            errors++;
            $display("FAIL basic_acc_state: in_ready=%b busy=%b, want 1 1", in_ready12, busy12);
        end
        in_valid = 1'b1; P = 8'hD2;
        @(negedge clk);
        checks++;
        if (out_valid12 !== 1'b0 || acc12 !== 12'h0D2) begin
            errors++;
            $display("FAIL basic_first: out_valid=%b acc=%h, want 0 0d2", out_valid12, acc12);
        end
        P = 8'h6E;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid12 !== 1'b1 || acc12 !== 12'h140 || ovf12 !== 1'b0 || in_ready12 !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: out_valid=%b acc=%h ovf=%b rdy=%b, want 1 140 0 0",
                     out_valid12, acc12, ovf12, in_ready12);
        end
        drain("basic");
    endtask

    task automatic test_overflow();
        logic [7:0] exp8;
`ifdef MAC4_ACCUM_SAT_EN
        exp8 = 8'hFF;
`else
        exp8 = 8'h01;
`endif
        @(negedge clk);
        start = 1'b1; len = 4'd2;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; P = 8'hFF;
        @(negedge clk);
        P = 8'h02;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid8 !== 1'b1 || ovf8 !== 1'b1 || acc8 !== exp8) begin
            errors++;
            $display("FAIL ovf_acc8: out_valid=%b ovf=%b acc=%h, want 1 1 %h",
                     out_valid8, ovf8, acc8, exp8);
        end
        checks++;
        if (ovf12 !== 1'b0 || acc12 !== 12'h101) begin
            errors++;
            $display("FAIL ovf_acc12: ovf=%b acc=%h, want 0 101", ovf12, acc12);
        end
        drain("ovf");
    endtask

    task automatic test_stall();
        logic [4:0] pat;
        pat = 5'b10101;
        @(negedge clk);
        start = 1'b1; len = 4'd3;
        @(negedge clk);
        start = 1'b0; P = 8'h38;
        for (int i = 0; i < 5; i++) begin
            in_valid = pat[4-i];
            @(negedge clk);
            if (i == 3) begin
                checks++;
                if (acc12 !== 12'h070 || in_ready12 !== 1'b1 || out_valid12 !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_hold: acc=%h rdy=%b ov=%b, want 070 1 0",
                             acc12, in_ready12, out_valid12);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid12 !== 1'b1 || acc12 !== 12'h0A8 || ovf12 !== 1'b0) begin
            errors++;
            $display("FAIL stall_result: out_valid=%b acc=%h ovf=%b, want 1 0a8 0",
                     out_valid12, acc12, ovf12);
        end
        drain("stall");
    endtask

    task automatic test_hold();
        int bad;
        bad = 0;
        @(negedge clk);
        start = 1'b1; len = 4'd1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; P = 8'h10;
        @(negedge clk);
        // Stimulus that must be ignored while HOLD waits on out_ready.
        in_valid = 1'b1; P = 8'hFF; len = 4'd5;
        for (int i = 0; i < 5; i++) begin
            start = i[0];
            if (out_valid12 !== 1'b1 || acc12 !== 12'h010 || ovf12 !== 1'b0 || in_ready12 !== 1'b0)
                bad++;
            @(negedge clk);
        end
        start = 1'b0; in_valid = 1'b0;
        checks++;
        if (bad != 0 || out_valid12 !== 1'b1 || acc12 !== 12'h010) begin
            errors++;
            $display("FAIL hold_stable: %0d unstable cycles, acc=%h ov=%b, want 0 010 1",
                     bad, acc12, out_valid12);
        end
        drain("hold");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; len = 4'd3;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; P = 8'h20;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (acc12 !== 12'h000 || busy12 !== 1'b0 || in_ready12 !== 1'b0 || ovf12 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: acc=%h busy=%b rdy=%b ovf=%b, want 000 0 0 0",
                     acc12, busy12, in_ready12, ovf12);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1; len = 4'd1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; P = 8'h48;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid12 !== 1'b1 || acc12 !== 12'h048) begin
            errors++;
            $display("FAIL reset_restart: out_valid=%b acc=%h, want 1 048", out_valid12, acc12);
        end
        drain("reset_mid");
    endtask

    task automatic test_len0();
        // ACC still shows 0x048 from the previous burst here.
        @(negedge clk);
        start = 1'b1; len = 4'd0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (out_valid12 !== 1'b1 || acc12 !== 12'h000 || ovf12 !== 1'b0 ||
            in_ready12 !== 1'b0 || busy12 !== 1'b1) begin
            errors++;
            $display("FAIL len0: ov=%b acc=%h ovf=%b rdy=%b busy=%b, want 1 000 0 0 1",
                     out_valid12, acc12, ovf12, in_ready12, busy12);
        end
        drain("len0");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_stall();
        test_hold();
        test_reset_mid();
        test_len0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac4_accum.md
MAC4_ACCUM -- requirements
Module: mac4_accum

Interface
REQ-001 Parameter ACC_W, default 12: accumulator width in bits; legal range 8..32.
REQ-002 Parameter LEN_W, default 4: width of the burst-length input.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 Port start  input  1: begin a burst; sampled only in IDLE.
REQ-006 Port len  input  LEN_W: number of products in the burst; sampled with start.
REQ-007 Port P  input  8: unsigned 4x4 product from the upstream multiplier.
REQ-008 Port in_valid  input  1: P is valid this cycle.
REQ-009 Port in_ready  output  1: block accepts P this cycle.
REQ-010 Port ACC  output  ACC_W: accumulated result.
REQ-011 Port OVF  output  1: sticky overflow flag for the current burst.
REQ-012 Port out_valid  output  1: ACC and OVF are final.
REQ-013 Port out_ready  input  1: downstream consumes the result.
REQ-014 Port busy  output  1: high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACC, HOLD.
REQ-016 In IDLE, start=1 with len!=0 SHALL clear ACC and OVF, load the remaining count with len, and enter ACC on the next edge.
REQ-017 In IDLE, start=1 with len=0 SHALL clear ACC and OVF and enter HOLD directly, producing result 0.
REQ-018 in_ready SHALL be 1 only in ACC; a product is accepted when in_valid & in_ready.
REQ-019 Each accepted product SHALL add zero-extended P to ACC and decrement the remaining count.
REQ-020 Accepting a product when the remaining count is 1 SHALL move the FSM to HOLD.
REQ-021 out_valid SHALL be 1 only in HOLD, asserting the cycle after the last product is accepted (1-cycle latency).
REQ-022 In HOLD, ACC and OVF SHALL remain stable until out_valid & out_ready; the FSM then returns to IDLE on that edge.
REQ-023 start SHALL be ignored in ACC and HOLD; in_valid SHALL be ignored outside ACC.
REQ-024 A carry out of bit ACC_W-1 on any accumulation SHALL set OVF; OVF stays set until the next burst starts.
REQ-025 In ACC with in_valid low, the state, ACC and the remaining count SHALL hold.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE with ACC=0, OVF=0, the remaining count at 0, in_ready=0, out_valid=0, and busy=0, including mid-burst or mid-HOLD.
REQ-027 After rst_n deasserts, the first start SHALL be honoured on the first rising edge at which it is sampled.

Configuration
REQ-028 With macro MAC4_ACCUM_SAT_EN defined, an overflowing accumulation SHALL leave ACC at all-ones, and ACC SHALL stay all-ones for the rest of the burst.
REQ-029 Without MAC4_ACCUM_SAT_EN, ACC SHALL wrap modulo 2^ACC_W; OVF behaviour is identical in both builds.

Structure
REQ-030 A shared package mac4_pkg SHALL hold the FSM state encoding (IDLE=2'b00, ACC=2'b01, HOLD=2'b10) and the product width constant (8).
REQ-031 A sub-module mac4_add SHALL perform the ACC_W-bit add of zero-extended P with carry out, including saturation when the macro is enabled.
REQ-032 All other logic, namely the FSM, counter and handshake, SHALL reside in mac4_accum.

Verification
REQ-033 With ACC_W=12, start with len=2 and products 0xD2 then 0x6E, both with in_valid=1 -> out_valid next cycle, ACC=0x140, OVF=0.
REQ-034 With ACC_W=8, len=2 and P=0xFF then 0x02 -> OVF=1; ACC=0xFF with MAC4_ACCUM_SAT_EN defined, ACC=0x01 without it.
REQ-035 len=3 with in_valid toggled 1,0,1,0,1 (P=0x38 each) -> exactly 3 accepts, ACC=0xA8, out_valid on the cycle after the third accept.
REQ-036 In HOLD with out_ready=0 for 5 cycles -> ACC, OVF and out_valid stable; start pulses ignored; out_ready=1 -> IDLE next edge.
REQ-037 rst_n pulsed low after 1 of 3 products is accepted -> ACC=0, busy=0, in_ready=0 immediately; a new start with len=1 and P=0x48 -> ACC=0x48.
REQ-038 start with len=0 -> HOLD next cycle, ACC=0, OVF=0, in_ready remains 0.
